// File: rtl/boot_seq_pkg.sv
// Shared types and default widths for the BIOS-to-user boot handoff sequencer.
package boot_seq_pkg;

    localparam int unsigned DEF_ADDR_W = 10;
    localparam int unsigned DEF_DATA_W = 32;
    // Largest copy a single load may request; larger counts are clamped to this.
    localparam int unsigned MAX_WORDS  = 1 << DEF_ADDR_W;

    typedef enum logic [2:0] {
        ST_BIOS,
        ST_REQ,
        ST_WAIT,
        ST_WRITE,
        ST_HANDOFF,
        ST_USER,
        ST_RETURN
    } boot_state_e;

endpackage

// File: rtl/boot_addr_gen.sv
// Copy bookkeeping: captured base/count, word index, wrapping source address,
// last-word detect and the running words_loaded count.
module boot_addr_gen
    import boot_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W:0]   count_i,
    input  logic              advance_i,
    output logic [ADDR_W-1:0] next_addr_c,
    output logic              last_c,
    output logic [ADDR_W:0]   index_o,
    output logic [ADDR_W:0]   words_loaded_o
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned CLAMP = 1 << ADDR_W;

    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  wl_q, wl_d;
    logic [CNT_W-1:0]  idx_inc;
    logic [CNT_W-1:0]  count_clamped;

    assign idx_inc       = idx_q + CNT_W'(1);
    assign count_clamped = (count_i > CNT_W'(CLAMP)) ? CNT_W'(CLAMP) : count_i;

    // Source address of the word about to be requested; wraps modulo 2^ADDR_W.
    assign next_addr_c    = start_i ? base_i : ADDR_W'(base_q + ADDR_W'(idx_inc));
    assign last_c         = (idx_inc == count_q);
    assign index_o        = idx_q;
    assign words_loaded_o = wl_q;

    // Capture on start, step index and loaded count on each written word.
    always_comb begin
        base_d  = base_q;
        count_d = count_q;
        idx_d   = idx_q;
        wl_d    = wl_q;
        if (start_i) begin
            base_d  = base_i;
            count_d = count_clamped;
            idx_d   = '0;
            wl_d    = '0;
        end else if (advance_i) begin
            idx_d = idx_inc;
            wl_d  = wl_q + CNT_W'(1);
        end
    end

    // Bookkeeping registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            base_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
            wl_q    <= '0;
        end else begin
            base_q  <= base_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            wl_q    <= wl_d;
        end
    end

endmodule

// File: rtl/boot_sequencer.sv
// Sequences the BIOS-to-user-program handoff: stalls the CPU, copies words from
// boot storage into instruction memory, pulses PC reset and flips the
// instruction source; a user-side request hands control back to BIOS.
module boot_sequencer
    import boot_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              load_req,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W:0]   load_count,
    input  logic              return_bios,
    output logic              src_rd,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [DATA_W-1:0] src_data,
    input  logic              src_valid,
    output logic              imem_wr_en,
    output logic [ADDR_W-1:0] imem_wr_addr,
    output logic [DATA_W-1:0] imem_wr_data,
    output logic              cpu_stall,
    output logic              pc_reset,
    output logic              user_sel,
    output logic [ADDR_W:0]   words_loaded
);

    boot_state_e state_q, state_d;

    logic              start;
    logic              advance;
    logic              last;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W:0]   index;

    logic              src_rd_q, src_rd_d;
    logic [ADDR_W-1:0] src_addr_q, src_addr_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              stall_q, stall_d;
    logic              pc_reset_q, pc_reset_d;
    logic              user_sel_q, user_sel_d;

    boot_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk_i          (clock),
        .rst_i          (rst),
        .start_i        (start),
        .base_i         (load_base),
        .count_i        (load_count),
        .advance_i      (advance),
        .next_addr_c    (next_addr),
        .last_c         (last),
        .index_o        (index),
        .words_loaded_o (words_loaded)
    );

    // Next state plus next values of every output, registered as a Moore decode of state_d.
    always_comb begin
        state_d    = state_q;
        start      = 1'b0;
        advance    = 1'b0;
        src_addr_d = src_addr_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        case (state_q)
            ST_BIOS: begin
                if (load_req) begin
                    start   = 1'b1;
                    state_d = (load_count == '0) ? ST_HANDOFF : ST_REQ;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (src_valid) begin
                    wr_addr_d = ADDR_W'(index);
                    wr_data_d = src_data;
                    state_d   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                advance = 1'b1;
                state_d = last ? ST_HANDOFF : ST_REQ;
            end
            ST_HANDOFF: begin
                state_d = ST_USER;
            end
            ST_USER: begin
                if (return_bios) begin
                    state_d = ST_RETURN;
                end
            end
            ST_RETURN: begin
                state_d = ST_BIOS;
            end
            default: begin
                state_d = ST_BIOS;
            end
        endcase

        if (state_d == ST_REQ) begin
            src_addr_d = next_addr;
        end

        src_rd_d   = (state_d == ST_REQ);
        wr_en_d    = (state_d == ST_WRITE);
        stall_d    = (state_d == ST_REQ) || (state_d == ST_WAIT) ||
                     (state_d == ST_WRITE) || (state_d == ST_HANDOFF);
        pc_reset_d = (state_d == ST_HANDOFF) || (state_d == ST_RETURN);
        // Instruction memory stays selected through RETURN so the source flips with the PC reset.
        user_sel_d = (state_d == ST_USER) || (state_d == ST_RETURN);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q    <= ST_BIOS;
            src_rd_q   <= 1'b0;
            src_addr_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            stall_q    <= 1'b0;
            pc_reset_q <= 1'b0;
            user_sel_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_rd_q   <= src_rd_d;
            src_addr_q <= src_addr_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            stall_q    <= stall_d;
            pc_reset_q <= pc_reset_d;
            user_sel_q <= user_sel_d;
        end
    end

    assign src_rd       = src_rd_q;
    assign src_addr     = src_addr_q;
    assign imem_wr_en   = wr_en_q;
    assign imem_wr_addr = wr_addr_q;
    assign imem_wr_data = wr_data_q;
    assign cpu_stall    = stall_q;
    assign pc_reset     = pc_reset_q;
    assign user_sel     = user_sel_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Bench for boot_sequencer: randomized storage latency and data, a queue
// scoreboard for reads/writes, and a handoff timing model.
module tb_boot_sequencer;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;

    logic          clock = 1'b0;
    logic          rst = 1'b1;
    logic          load_req = 1'b0;
    logic [AW-1:0] load_base = '0;
    logic [AW:0]   load_count = '0;
    logic          return_bios = 1'b0;
    logic          src_rd;
    logic [AW-1:0] src_addr;
    logic [DW-1:0] src_data;
    logic          src_valid;
    logic          imem_wr_en;
    logic [AW-1:0] imem_wr_addr;
    logic [DW-1:0] imem_wr_data;
    logic          cpu_stall;
    logic          pc_reset;
    logic          user_sel;
    logic [AW:0]   words_loaded;

    boot_sequencer #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clock        (clock),
        .rst          (rst),
        .load_req     (load_req),
        .load_base    (load_base),
        .load_count   (load_count),
        .return_bios  (return_bios),
        .src_rd       (src_rd),
        .src_addr     (src_addr),
        .src_data     (src_data),
        .src_valid    (src_valid),
        .imem_wr_en   (imem_wr_en),
        .imem_wr_addr (imem_wr_addr),
        .imem_wr_data (imem_wr_data),
        .cpu_stall    (cpu_stall),
        .pc_reset     (pc_reset),
        .user_sel     (user_sel),
        .words_loaded (words_loaded)
    );

    initial forever #5 clock = ~clock;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    int            checks = 0;
    int            errors = 0;
    bit            armed = 1'b0;
    logic [DW-1:0] store [1024];
    int            lat_lo = 1;
    int            lat_hi = 1;
    bit            spurious = 1'b0;
    logic [AW-1:0] exp_rd [$];
    wr_t           exp_wr [$];
    int            rd_seen = 0;
    int            wr_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Boot storage model: answers each read after a random latency, optionally
    // injecting junk valid pulses whenever no read is outstanding.
    initial begin
        int            pending = 0;
        logic [AW-1:0] raddr = '0;
        src_valid = 1'b0;
        src_data  = '0;
        forever begin
            @(negedge clock);
            src_valid = 1'b0;
            if (pending > 0) begin
                pending--;
                if (pending == 0) begin
                    src_valid = 1'b1;
                    src_data  = store[raddr];
                end
            end else begin
                if (src_rd === 1'b1) begin
                    pending = $urandom_range(lat_hi, lat_lo);
                    raddr   = src_addr;
                end
                if (spurious && ($urandom_range(3, 0) == 0)) begin
                    src_valid = 1'b1;
                    src_data  = $urandom;
                end
            end
        end
    end

    // Monitor: scoreboards reads and writes, and checks pc_reset/user_sel rules.
    initial begin
        logic prev_pc = 1'b0;
        logic prev_us = 1'b0;
        wr_t  w;
        logic [AW-1:0] ea;
        forever begin
            @(negedge clock);
            if (armed) begin
                if (src_rd === 1'b1) begin
                    rd_seen++;
                    if (exp_rd.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_read: src_addr 0x%0h, no read expected", src_addr);
                    end else begin
                        ea = exp_rd.pop_front();
                        chk("read_addr", 64'(src_addr), 64'(ea));
                    end
                end
                if (imem_wr_en === 1'b1) begin
                    wr_seen++;
                    if (exp_wr.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected",
                                 imem_wr_addr, imem_wr_data);
                    end else begin
                        w = exp_wr.pop_front();
                        chk("write_addr", 64'(imem_wr_addr), 64'(w.a));
                        chk("write_data", 64'(imem_wr_data), 64'(w.d));
                    end
                end
                if (pc_reset === 1'b1 && prev_pc === 1'b1) begin
                    checks++;
                    errors++;
                    $display("FAIL pc_reset_width: high for two consecutive cycles at %0t", $time);
                end
                if (user_sel !== prev_us) begin
                    chk("user_sel_change_after_pc_reset", 64'(prev_pc), 64'd1);
                end
            end
            prev_pc = pc_reset;
            prev_us = user_sel;
        end
    end

    // Issue one load; reference: N = min(count, 1024), reads base+i (wrapping),
    // writes i <- store[base+i], user_sel up N*(L+2)+1 cycles after the first REQ.
    task automatic run_load(input logic [AW-1:0] base, input logic [AW:0] cnt,
                            input bit timed, input int lat);
        int            n;
        int            cycles;
        logic [AW-1:0] a;
        n = (cnt > 11'd1024) ? 1024 : int'(cnt);
        for (int i = 0; i < n; i++) begin
            a = AW'(int'(base) + i);
            exp_rd.push_back(a);
            exp_wr.push_back('{a: AW'(i), d: store[a]});
        end
        @(negedge clock);
        load_req   = 1'b1;
        load_base  = base;
        load_count = cnt;
        @(negedge clock);
        load_req = 1'b0;
        chk("stall_rise", 64'(cpu_stall), 64'd1);
        if (n == 0) begin
            chk("zero_count_pc_reset", 64'(pc_reset), 64'd1);
            chk("zero_count_user_sel_low", 64'(user_sel), 64'd0);
        end else begin
            chk("first_req", 64'(src_rd), 64'd1);
        end
        cycles = 0;
        while (user_sel !== 1'b1 && cycles < 5000) begin
            @(negedge clock);
            cycles++;
        end
        if (user_sel !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL handoff_timeout: user_sel still %b after %0d cycles", user_sel, cycles);
            exp_rd.delete();
            exp_wr.delete();
        end else if (timed) begin
            chk("handoff_cycles", 64'(cycles), 64'(n * (lat + 2) + 1));
        end
        chk("words_loaded", 64'(words_loaded), 64'(n));
        chk("user_stall_low", 64'(cpu_stall), 64'd0);
        chk("reads_drained", 64'(exp_rd.size()), 64'd0);
        chk("writes_drained", 64'(exp_wr.size()), 64'd0);
    endtask

    task automatic do_return();
        @(negedge clock);
        return_bios = 1'b1;
        load_req    = 1'b1;
        @(negedge clock);
        return_bios = 1'b0;
        load_req    = 1'b0;
        chk("return_pc_reset", 64'(pc_reset), 64'd1);
        chk("return_stall", 64'(cpu_stall), 64'd0);
        @(negedge clock);
        chk("return_user_sel", 64'(user_sel), 64'd0);
        chk("return_pc_reset_low", 64'(pc_reset), 64'd0);
        chk("return_no_read", 64'(src_rd), 64'd0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_src_rd"}, 64'(src_rd), 64'd0);
        chk({tag, "_src_addr"}, 64'(src_addr), 64'd0);
        chk({tag, "_wr_en"}, 64'(imem_wr_en), 64'd0);
        chk({tag, "_wr_addr"}, 64'(imem_wr_addr), 64'd0);
        chk({tag, "_wr_data"}, 64'(imem_wr_data), 64'd0);
        chk({tag, "_stall"}, 64'(cpu_stall), 64'd0);
        chk({tag, "_pc_reset"}, 64'(pc_reset), 64'd0);
        chk({tag, "_user_sel"}, 64'(user_sel), 64'd0);
        chk({tag, "_words_loaded"}, 64'(words_loaded), 64'd0);
    endtask

    initial begin
        int t0;
        int w0;
        int k;
        for (int i = 0; i < 1024; i++) store[i] = $urandom;

        repeat (3) @(negedge clock);
        check_reset_values("reset");
        rst = 1'b0;
        armed = 1'b1;

        // Directed: base 0x010, three words, latency 1.
        run_load(10'h010, 11'd3, 1'b1, 1);
        // Loads requested from USER are ignored.
        @(negedge clock);
        load_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("user_ignore_load_rd", 64'(src_rd), 64'd0);
            chk("user_ignore_load_stall", 64'(cpu_stall), 64'd0);
            chk("user_ignore_load_sel", 64'(user_sel), 64'd1);
        end
        load_req = 1'b0;
        do_return();

        // Zero-length load goes straight to handoff.
        run_load(10'h123, 11'd0, 1'b1, 1);
        do_return();

        // Source address wraps past the top of storage.
        lat_lo = 2;
        lat_hi = 2;
        run_load(10'h3FE, 11'd4, 1'b1, 2);
        do_return();

        // return_bios is ignored while in BIOS.
        @(negedge clock);
        return_bios = 1'b1;
        @(negedge clock);
        return_bios = 1'b0;
        chk("bios_ignore_return_pc", 64'(pc_reset), 64'd0);
        @(negedge clock);
        chk("bios_ignore_return_pc2", 64'(pc_reset), 64'd0);
        chk("bios_ignore_return_sel", 64'(user_sel), 64'd0);

        // Random loads with random latency and spurious valid pulses.
        lat_lo   = 1;
        lat_hi   = 5;
        spurious = 1'b1;
        for (int r = 0; r < 6; r++) begin
            run_load(AW'($urandom_range(1023, 0)), 11'($urandom_range(12, 1)), 1'b0, 0);
            do_return();
        end

        // Oversized count clamps to the full 1024-word memory.
        spurious = 1'b0;
        lat_lo   = 1;
        lat_hi   = 1;
        run_load(10'h200, 11'd1500, 1'b1, 1);
        do_return();

        // Reset while waiting on the second of five words.
        lat_lo = 4;
        lat_hi = 4;
        for (int i = 0; i < 5; i++) begin
            exp_rd.push_back(AW'(10'h100 + i));
            exp_wr.push_back('{a: AW'(i), d: store[10'h100 + i]});
        end
        t0 = rd_seen;
        w0 = wr_seen;
        @(negedge clock);
        load_req   = 1'b1;
        load_base  = 10'h100;
        load_count = 11'd5;
        @(negedge clock);
        load_req = 1'b0;
        k = 0;
        while (rd_seen < t0 + 2 && k < 100) begin
            @(negedge clock);
            k++;
        end
        if (rd_seen < t0 + 2) begin
            checks++;
            errors++;
            $display("FAIL mid_wait_second_read: saw %0d reads, expected 2", rd_seen - t0);
        end
        @(negedge clock);
        rst = 1'b1;
        exp_rd.delete();
        exp_wr.delete();
        @(negedge clock);
        check_reset_values("mid_reset");
        rst = 1'b0;
        repeat (8) @(negedge clock);
        chk("post_reset_user_sel", 64'(user_sel), 64'd0);
        chk("post_reset_words_loaded", 64'(words_loaded), 64'd0);
        chk("post_reset_write_count", 64'(wr_seen - w0), 64'd1);

        // A fresh load after reset completes normally.
        lat_lo = 3;
        lat_hi = 3;
        run_load(10'h2A5, 11'd2, 1'b1, 3);
        do_return();

        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
